// File: rtl/pipe_pkg.sv
// Shared types and constants for the valid/ready pipeline stage with skid buffer.
package pipe_pkg;

    localparam int PIPE_CNT_W = 2;

    // 2'd3 is unused; the stage steers it back to EMPTY.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    function automatic logic [PIPE_CNT_W-1:0] state_count(input pipe_state_e s);
        logic [PIPE_CNT_W-1:0] c;
        case (s)
            BUSY:    c = 2'd1;
            FULL:    c = 2'd2;
            default: c = 2'd0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Upstream and downstream valid/ready handshake of one pipeline stage.
interface pipe_stage_skid_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    // master: the environment around the stage (producer and consumer).
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // slave: the stage itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_skid_en_reg.sv
// WIDTH-bit register with load enable and synchronous active-low reset to RESET_VAL.
module en_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= RESET_VAL;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline register stage with valid/ready handshake, one-entry skid buffer and flush.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    pipe_stage_skid_if.slave      bus,
    output logic [PIPE_CNT_W-1:0] count
);

    pipe_state_e           state_q, state_d;
    logic                  out_valid_q;
    logic                  in_ready_q;
    logic [PIPE_CNT_W-1:0] count_q;

    logic [WIDTH-1:0]      main_q, main_d, skid_q;
    logic                  main_en, skid_en;
    logic                  in_fire, out_fire;

    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = out_valid_q & bus.out_ready;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = bus.in_data;

        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_en = 1'b1;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_en = 1'b1;
                    end else if (in_fire) begin
                        skid_en = 1'b1;
                        state_d = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // Downstream drained main: the older skid entry moves up.
                    if (out_fire) begin
                        main_en = 1'b1;
                        main_d  = skid_q;
                        state_d = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Handshake outputs come from their own flops, fed by the decode of the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d != EMPTY);
            in_ready_q  <= (state_d != FULL);
            count_q     <= state_count(state_d);
        end
    end

    en_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk   (clk),
        .reset (reset),
        .en_i  (main_en),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    en_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .en_i  (skid_en),
        .d_i   (bus.in_data),
        .q_o   (skid_q)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;
    assign count         = count_q;

    a_count_range: assert property (@(posedge clk) disable iff (!reset)
        count_q <= 2'd2);
    a_ready_vs_count: assert property (@(posedge clk) disable iff (!reset)
        in_ready_q == (count_q != 2'd2));
    a_valid_vs_count: assert property (@(posedge clk) disable iff (!reset)
        out_valid_q == (count_q != 2'd0));

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline register stage with a valid/ready handshake and a one-entry skid buffer.
- Generalises the team's fixed 8-bit register in three ways: configurable width and reset value, backpressure, and flush.
- Used between stages when the single-cycle datapath is split into a pipeline, e.g. IF/ID and ID/EX.
- Sustains one transfer per cycle with fully registered outputs, including in_ready.

Parameters:
- WIDTH, 8, payload width in bits (legal range 1 and up).
- RESET_VAL, {WIDTH{1'b0}}, value loaded into out_data on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; the stage is reset when reset=0 at a clk rising edge.
- flush  input  1  discards all held entries and any same-cycle input.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  stage can accept; registered.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  payload; registered.
- count  output  2  occupancy, 0..2.

Behaviour:
- Handshake definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - A transfer occurs only on a fire; data is sampled at the clk edge.
- State machine, 2-bit state: EMPTY (count 0), BUSY (main reg valid, count 1), FULL (main and skid valid, count 2).
- Outputs decoded from state:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL).
  - count encodes the occupancy.
  - out_data is always the main register.
- Priority at each edge: reset, then flush, then the normal transitions.
- Reset (reset=0):
  - state=EMPTY, so out_valid=0, in_ready=1, count=0.
  - out_data=RESET_VAL; skid register=RESET_VAL.
  - This holds regardless of in_valid, flush and out_ready.
- Flush (reset=1, flush=1):
  - state=EMPTY.
  - A same-cycle in_fire is dropped.
  - A same-cycle out_fire still counts as consumed downstream; the stage takes no further action for it.
  - Data registers hold their old values; they are don't-care while out_valid=0.
- Transitions from EMPTY:
  - in_fire: main<=in_data, go to BUSY.
  - Otherwise stay in EMPTY.
- Transitions from BUSY:
  - in_fire & out_fire: main<=in_data, stay in BUSY (full throughput).
  - in_fire & !out_ready: skid<=in_data, go to FULL.
  - out_fire & !in_valid: go to EMPTY.
  - Otherwise hold.
- Transitions from FULL (in_ready=0):
  - out_fire: main<=skid, go to BUSY.
  - in_valid is ignored.
  - Otherwise hold.
- Latency and throughput: one cycle from in_fire to out_valid. Sustained rate is one transfer per clk when out_ready=1.
- Ordering: strict FIFO; no entry is lost or duplicated except by flush or reset.
- Reset mid-operation: any held entries are discarded and the stage returns to the reset values above.

Decomposition:
- Shared package pipe_pkg holds:
  - the state typedef with encodings EMPTY=2'd0, BUSY=2'd1, FULL=2'd2 (2'd3 is illegal and must recover to EMPTY);
  - the constant PIPE_CNT_W=2.
- Sub-module en_reg, instantiated twice (main and skid):
  - parametrised WIDTH-bit register with load enable;
  - synchronous active-low reset to a RESET_VAL parameter.

Test Plan:
- Reset: reset=0 for 2 cycles with in_valid=1 and in_data=8'hA5 → out_valid=0, in_ready=1, count=0, out_data=8'h00. After release, the first in_fire of 8'h11 gives out_data=8'h11 and out_valid=1 on the next edge.
- Streaming: out_ready=1; push 8'h01..8'h10 on consecutive cycles → each value appears one cycle later in order. in_ready stays 1 and count stays 1 throughout.
- Backpressure:
  - Push 8'h21 then 8'h22 with out_ready=0 → count=2, in_ready=0; 8'h23 held on the input is not accepted.
  - Then raise out_ready → observe 8'h21, 8'h22, 8'h23 in order with no gaps or duplicates.
- Flush from FULL: with 8'h31 and 8'h32 held, assert flush together with in_valid carrying 8'h33 → next cycle count=0, out_valid=0, in_ready=1. 8'h33 never appears at the output.
- Reset mid-stream: with count=2, pull reset=0 for 1 cycle → out_data=RESET_VAL and count=0. Repeat with WIDTH=32 and RESET_VAL=32'hDEADBEEF.
- Random scoreboard: 10k cycles of random in_valid and out_ready with 10% flush → the output sequence matches a reference queue. Assertions: count≤2, and in_ready = (count≠2).
